// File: rtl/secuenciador_seguidor.sv
// ============================================================================
//  Module      : secuenciador_seguidor
//  Description : Line-follower run-time controller. Sensor sync/debounce,
//                mode FSM and per-motor PWM/direction generation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module secuenciador_seguidor #(
    parameter int PWM_BITS     = 8,
    parameter int DEB_CYCLES   = 1000,
    parameter int DUTY_FWD     = 200,
    parameter int DUTY_TURN    = 100,
    parameter int TURN_LIMIT   = 50000,
    parameter int SEARCH_LIMIT = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       sensor_derecho,
    input  logic       sensor_izquierdo,
    output logic       ENA,
    output logic       IN1,
    output logic       ENB,
    output logic       IN3,
    output logic [2:0] estado,
    output logic       perdido
);

    localparam int c_DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int c_MAX_LIM = (TURN_LIMIT > SEARCH_LIMIT) ? TURN_LIMIT : SEARCH_LIMIT;
    localparam int c_CNT_W   = $clog2(c_MAX_LIM + 1);

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST   = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_TURN_END   = c_CNT_W'(TURN_LIMIT - 1);
    localparam logic [c_CNT_W-1:0]  c_SEARCH_END = c_CNT_W'(SEARCH_LIMIT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX    = '1;
    localparam logic [PWM_BITS-1:0] c_DUTY_FWD   = PWM_BITS'(DUTY_FWD);
    localparam logic [PWM_BITS-1:0] c_DUTY_TURN  = PWM_BITS'(DUTY_TURN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FWD    = 3'd1,
        S_LEFT   = 3'd2,
        S_RIGHT  = 3'd3,
        S_SEARCH = 3'd4,
        S_END    = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Bit 1 = left sensor, bit 0 = right sensor, so the pattern reads {izq, der}
    logic [1:0] w_raw;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_pat;

    assign w_raw = {sensor_izquierdo, sensor_derecho};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            logic [c_DEB_W-1:0] r_stab;
            logic               r_deb;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_stab <= '0;
                    r_deb  <= 1'b0;
                end else if (r_sync2[gi] != r_deb) begin
                    if (r_stab == c_DEB_LAST) begin
                        r_deb  <= r_sync2[gi];
                        r_stab <= '0;
                    end else begin
                        r_stab <= r_stab + 1'b1;
                    end
                end else begin
                    r_stab <= '0;
                end
            end

            assign w_pat[gi] = r_deb;
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_dir_right;
    logic                 w_dir_nxt;
    logic [c_CNT_W-1:0]   r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir_right;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_END, S_HALT: begin
                    if (start) w_state_nxt = S_FWD;
                end
                S_FWD, S_LEFT, S_RIGHT: begin
                    case (w_pat)
                        2'b00:   w_state_nxt = S_FWD;
                        2'b10:   w_state_nxt = S_LEFT;
                        2'b01:   w_state_nxt = S_RIGHT;
                        default: w_state_nxt = S_END;
                    endcase
                    // A turn held too long with no pattern change means the line was lost
                    if (r_state != S_FWD && w_state_nxt == r_state && r_cnt == c_TURN_END) begin
                        w_state_nxt = S_SEARCH;
                        w_dir_nxt   = (r_state == S_RIGHT);
                    end
                end
                S_SEARCH: begin
                    if (w_pat == 2'b00)
                        w_state_nxt = S_FWD;
                    else if (w_pat == 2'b11)
                        w_state_nxt = S_END;
                    else if (w_pat == (r_dir_right ? 2'b10 : 2'b01))
                        w_state_nxt = r_dir_right ? S_LEFT : S_RIGHT;
                    else if (r_cnt == c_SEARCH_END)
                        w_state_nxt = S_HALT;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_dir_right <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dir_right <= w_dir_nxt;
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (r_cnt != c_CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    logic [PWM_BITS-1:0] w_duty_a;
    logic [PWM_BITS-1:0] w_duty_b;
    logic                w_in1;
    logic                w_in3;

    always_comb begin
        w_duty_a = '0;
        w_duty_b = '0;
        w_in1    = 1'b0;
        w_in3    = 1'b0;
        case (r_state)
            S_FWD: begin
                w_duty_a = c_DUTY_FWD;
                w_duty_b = c_DUTY_FWD;
                w_in1    = 1'b1;
                w_in3    = 1'b1;
            end
            S_LEFT: begin
                w_duty_a = c_DUTY_TURN;
                w_duty_b = c_DUTY_FWD;
                w_in1    = 1'b1;
                w_in3    = 1'b1;
            end
            S_RIGHT: begin
                w_duty_a = c_DUTY_FWD;
                w_duty_b = c_DUTY_TURN;
                w_in1    = 1'b1;
                w_in3    = 1'b1;
            end
            S_SEARCH: begin
                // Pivot in place, spinning back toward the side the line was last seen
                w_duty_a = c_DUTY_TURN;
                w_duty_b = c_DUTY_TURN;
                w_in1    = r_dir_right;
                w_in3    = ~r_dir_right;
            end
            default: ;
        endcase
    end

    logic [PWM_BITS-1:0] r_pwm;
    logic [PWM_BITS-1:0] w_pwm_nxt;
    logic                r_ena;
    logic                r_enb;
    logic                r_in1;
    logic                r_in3;

    assign w_pwm_nxt = r_pwm + 1'b1;

    // Enables are compared against the post-edge counter so EN = (cnt < duty) holds on the pins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm <= '0;
            r_ena <= 1'b0;
            r_enb <= 1'b0;
            r_in1 <= 1'b0;
            r_in3 <= 1'b0;
        end else begin
            r_pwm <= w_pwm_nxt;
            r_ena <= (w_pwm_nxt < w_duty_a);
            r_enb <= (w_pwm_nxt < w_duty_b);
            r_in1 <= w_in1;
            r_in3 <= w_in3;
        end
    end

    assign ENA     = r_ena;
    assign ENB     = r_enb;
    assign IN1     = r_in1;
    assign IN3     = r_in3;
    assign estado  = r_state;
    assign perdido = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_secuenciador_seguidor.sv
// ============================================================================
//  Module      : tb_secuenciador_seguidor
//  Description : Self-checking bench for secuenciador_seguidor with a
//                behavioural reference model and randomized sensor traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_secuenciador_seguidor;

    localparam int PWM_BITS = 4;
    localparam int DEB      = 4;
    localparam int DFWD     = 12;
    localparam int DTURN    = 6;
    localparam int TL       = 100;
    localparam int SL       = 200;

    localparam int IDLE = 0, FWD = 1, LEFT = 2, RIGHT = 3, SEARCH = 4, ENDM = 5, HALT = 6;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       s_der = 1'b0;
    logic       s_izq = 1'b0;
    logic       ENA, IN1, ENB, IN3, perdido;
    logic [2:0] estado;

    int n_tests = 0;
    int n_fail  = 0;

    secuenciador_seguidor #(
        .PWM_BITS(PWM_BITS), .DEB_CYCLES(DEB), .DUTY_FWD(DFWD),
        .DUTY_TURN(DTURN), .TURN_LIMIT(TL), .SEARCH_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sensor_derecho(s_der), .sensor_izquierdo(s_izq),
        .ENA(ENA), .IN1(IN1), .ENB(ENB), .IN3(IN3),
        .estado(estado), .perdido(perdido)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_state, m_dir, m_out_state, m_out_dir, m_dwell, m_pwm;
    bit m_s1_i, m_s2_i, m_s1_d, m_s2_d, m_deb_i, m_deb_d;
    bit q_i[$];
    bit q_d[$];

    function automatic bit settled(input bit q[$], input bit cur);
        if (q.size() < DEB) return 1'b0;
        foreach (q[k]) if (q[k] == cur) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int pat_state(input int p);
        case (p)
            0: return FWD;
            2: return LEFT;
            1: return RIGHT;
            default: return ENDM;
        endcase
    endfunction

    function automatic int exp_duty(input int st, input bit left_motor);
        case (st)
            FWD:    return DFWD;
            LEFT:   return left_motor ? DTURN : DFWD;
            RIGHT:  return left_motor ? DFWD : DTURN;
            SEARCH: return DTURN;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_pin(input int st, input int dir, input bit left_motor);
        case (st)
            FWD, LEFT, RIGHT: return 1'b1;
            SEARCH: return left_motor ? (dir == RIGHT) : (dir == LEFT);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = IDLE; m_dir = LEFT; m_out_state = IDLE; m_out_dir = LEFT;
        m_dwell = 0; m_pwm = 0;
        m_s1_i = 0; m_s2_i = 0; m_s1_d = 0; m_s2_d = 0; m_deb_i = 0; m_deb_d = 0;
        q_i.delete(); q_d.delete();
    endtask

    task automatic model_step();
        int p, nxt, ndir;
        bit ndeb_i, ndeb_d;
        p    = {m_deb_i, m_deb_d};
        nxt  = m_state;
        ndir = m_dir;
        if (stop) begin
            nxt = IDLE;
        end else if (m_state inside {IDLE, ENDM, HALT}) begin
            if (start) nxt = FWD;
        end else if (m_state inside {FWD, LEFT, RIGHT}) begin
            nxt = pat_state(p);
            if (m_state != FWD && nxt == m_state && m_dwell + 1 >= TL) begin
                nxt  = SEARCH;
                ndir = m_state;
            end
        end else if (m_state == SEARCH) begin
            if (p == 0) nxt = FWD;
            else if (p == 3) nxt = ENDM;
            else if (p == ((m_dir == LEFT) ? 1 : 2)) nxt = (m_dir == LEFT) ? RIGHT : LEFT;
            else if (m_dwell + 1 >= SL) nxt = HALT;
        end

        // A debounced value moves once the last DEB synchronised samples all disagree with it
        ndeb_i = m_deb_i;
        q_i.push_back(m_s2_i);
        if (q_i.size() > DEB) void'(q_i.pop_front());
        if (settled(q_i, m_deb_i)) begin ndeb_i = ~m_deb_i; q_i.delete(); end
        ndeb_d = m_deb_d;
        q_d.push_back(m_s2_d);
        if (q_d.size() > DEB) void'(q_d.pop_front());
        if (settled(q_d, m_deb_d)) begin ndeb_d = ~m_deb_d; q_d.delete(); end

        m_out_state = m_state;
        m_out_dir   = m_dir;
        m_dwell     = (nxt != m_state) ? 0 : m_dwell + 1;
        m_state     = nxt;
        m_dir       = ndir;
        m_pwm       = (m_pwm + 1) % (1 << PWM_BITS);
        m_deb_i = ndeb_i; m_deb_d = ndeb_d;
        m_s2_i = m_s1_i; m_s1_i = s_izq;
        m_s2_d = m_s1_d; m_s1_d = s_der;
    endtask

    initial model_reset();

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("estado",  estado,  m_state);
        check("perdido", perdido, m_state == HALT);
        check("ENA", ENA, m_pwm < exp_duty(m_out_state, 1'b1));
        check("ENB", ENB, m_pwm < exp_duty(m_out_state, 1'b0));
        check("IN1", IN1, exp_pin(m_out_state, m_out_dir, 1'b1));
        check("IN3", IN3, exp_pin(m_out_state, m_out_dir, 1'b0));
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input int target, input int max_cyc, output int n);
        n = 0;
        while (estado !== 3'(target) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (estado !== 3'(target)) check("wait_state_timeout", estado, target);
    endtask

    task automatic count_high(input int n, output int a, output int b);
        a = 0;
        b = 0;
        repeat (n) begin
            @(negedge clk);
            a += int'(ENA);
            b += int'(ENB);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, b, len;

        cyc(3);
        check("rst_estado", estado, 0);
        check("rst_ENA", ENA, 0);
        check("rst_IN1", IN1, 0);
        #2 reset = 1'b1;
        cyc(2);

        pulse_start();
        check("start_fwd", estado, FWD);
        cyc(1);
        count_high(16, a, b);
        check("fwd_ena_duty", a, 12);
        check("fwd_enb_duty", b, 12);
        check("fwd_in1", IN1, 1);
        check("fwd_in3", IN3, 1);

        s_izq = 1'b1; cyc(3); s_izq = 1'b0;
        cyc(12);
        check("glitch_ignored", estado, FWD);

        s_izq = 1'b1;
        wait_state(LEFT, 40, n);
        check("deb_latency_state", n, 7);
        cyc(1);
        count_high(16, a, b);
        check("left_ena_duty", a, 6);
        check("left_enb_duty", b, 12);

        s_izq = 1'b0;
        wait_state(FWD, 40, n);
        s_der = 1'b1;
        wait_state(RIGHT, 40, n);
        wait_state(SEARCH, 300, n);
        check("turn_dwell", n, TL);
        cyc(1);
        check("search_in1", IN1, 1);
        check("search_in3", IN3, 0);
        count_high(16, a, b);
        check("search_ena_duty", a, 6);
        check("search_enb_duty", b, 6);
        wait_state(HALT, 400, n);
        check("search_dwell", n + 17, SL);
        check("halt_perdido", perdido, 1);
        cyc(1);
        count_high(16, a, b);
        check("halt_motors_off", a + b, 0);
        pulse_start();
        check("halt_restart", estado, FWD);
        check("halt_perdido_clr", perdido, 0);

        wait_state(RIGHT, 40, n);
        wait_state(SEARCH, 300, n);
        s_der = 1'b0;
        wait_state(FWD, 40, n);
        check("search_exit_fwd_latency", n, 7);

        s_der = 1'b1;
        wait_state(RIGHT, 40, n);
        wait_state(SEARCH, 300, n);
        s_der = 1'b0;
        s_izq = 1'b1;
        wait_state(LEFT, 40, n);
        check("search_to_left", estado, LEFT);

        s_der = 1'b1;
        wait_state(ENDM, 40, n);
        cyc(1);
        check("end_pins", {ENA, ENB, IN1, IN3}, 0);
        pulse_start();
        check("end_start_fwd", estado, FWD);
        cyc(1);
        check("end_back_to_end", estado, ENDM);

        stop = 1'b1; cyc(1); stop = 1'b0;
        check("stop_idle", estado, IDLE);
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        check("start_stop_same", estado, IDLE);
        cyc(1);
        check("start_stop_hold", estado, IDLE);

        s_izq = 1'b0; s_der = 1'b0;
        cyc(10);
        pulse_start();
        cyc(1);
        n = 0;
        while (ENA !== 1'b1 && n < 20) begin cyc(1); n++; end
        check("pre_reset_ena_high", ENA, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ENA", ENA, 0);
        check("async_rst_estado", estado, IDLE);
        @(negedge clk);
        #2 reset = 1'b1;
        cyc(2);

        for (int seg = 0; seg < 80; seg++) begin
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 6);
                1:       len = $urandom_range(250, 420);
                default: len = $urandom_range(5, 160);
            endcase
            s_izq = 1'($urandom_range(0, 1));
            s_der = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                start = ($urandom_range(0, 29) == 0);
                stop  = ($urandom_range(0, 199) == 0);
                @(negedge clk);
            end
            start = 1'b0;
            stop  = 1'b0;
        end

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
